// File: rtl/sram_rw0_ctrl_if.sv
// Request/response channels and macro RW0 port for the SRAM access controller.
// The controller takes the slave modport; the client and macro side take the master modport.
interface sram_rw0_ctrl_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 160,
  parameter int LANES  = 4
);
  logic              r_valid;
  logic              r_ready;
  logic [ADDR_W-1:0] r_addr;
  logic              r_resp_valid;
  logic [DATA_W-1:0] r_resp_data;

  logic              w_valid;
  logic              w_ready;
  logic [ADDR_W-1:0] w_addr;
  logic [LANES-1:0]  w_mask;
  logic [DATA_W-1:0] w_data;

  logic              init_done;

  logic [ADDR_W-1:0] RW0_addr;
  logic              RW0_en;
  logic              RW0_wmode;
  logic [LANES-1:0]  RW0_wmask;
  logic [DATA_W-1:0] RW0_wdata;
  logic [DATA_W-1:0] RW0_rdata;

  modport slave (
    input  r_valid, r_addr, w_valid, w_addr, w_mask, w_data, RW0_rdata,
    output r_ready, r_resp_valid, r_resp_data, w_ready, init_done,
           RW0_addr, RW0_en, RW0_wmode, RW0_wmask, RW0_wdata
  );

  modport master (
    output r_valid, r_addr, w_valid, w_addr, w_mask, w_data, RW0_rdata,
    input  r_ready, r_resp_valid, r_resp_data, w_ready, init_done,
           RW0_addr, RW0_en, RW0_wmode, RW0_wmask, RW0_wdata
  );
endinterface

// File: rtl/sram_rw0_ctrl.sv
// Arbitrates read and write channels onto one RW0 SRAM port, zero-fills the array
// after reset, and holds read data stable between responses.
module sram_rw0_ctrl #(
  parameter int DEPTH   = 128,
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 160,
  parameter int LANES   = 4,
  parameter int INIT_EN = 1
) (
  input logic            clock,
  input logic            reset_n,
  sram_rw0_ctrl_if.slave bus
);

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  localparam state_t RESET_ST = (INIT_EN != 0) ? ST_INIT : ST_RUN;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_init_ptr;
  logic              r_prio_rd;   // 1: next conflict goes to the read side
  logic              r_pend;
  logic [DATA_W-1:0] r_hold;
  logic              r_init_done;

  logic              w_grant_w;
  logic              w_grant_r;
  logic              w_conflict;
  logic              w_en;
  logic              w_wmode;
  logic [ADDR_W-1:0] w_addr_mux;
  logic [LANES-1:0]  w_wmask_mux;
  logic [DATA_W-1:0] w_wdata_mux;

  // Outputs are gated by reset_n so the port is quiet while reset is held.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_w   = 1'b0;
    w_grant_r   = 1'b0;
    w_conflict  = 1'b0;
    w_en        = 1'b0;
    w_wmode     = 1'b0;
    w_addr_mux  = '0;
    w_wmask_mux = '0;
    w_wdata_mux = '0;
    if (reset_n) begin
      case (r_state)
        ST_INIT: begin
          w_en        = 1'b1;
          w_wmode     = 1'b1;
          w_addr_mux  = r_init_ptr;
          w_wmask_mux = '1;
          if (r_init_ptr == ADDR_W'(DEPTH - 1))
            w_state_nxt = ST_RUN;
        end
        ST_RUN: begin
          w_conflict = bus.r_valid && bus.w_valid;
          w_grant_w  = bus.w_valid && (!r_prio_rd || !bus.r_valid);
          w_grant_r  = bus.r_valid && (r_prio_rd || !bus.w_valid);
          w_en       = w_grant_w || w_grant_r;
          w_wmode    = w_grant_w;
          if (w_grant_w) begin
            w_addr_mux  = bus.w_addr;
            w_wmask_mux = bus.w_mask;
            w_wdata_mux = bus.w_data;
          end else if (w_grant_r) begin
            w_addr_mux  = bus.r_addr;
          end
        end
        default: w_state_nxt = RESET_ST;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= RESET_ST;
      r_init_ptr  <= '0;
      r_prio_rd   <= 1'b0;
      r_pend      <= 1'b0;
      r_hold      <= '0;
      r_init_done <= (INIT_EN == 0);
    end else begin
      r_state     <= w_state_nxt;
      r_init_done <= (w_state_nxt == ST_RUN);
      if (r_state == ST_INIT)
        r_init_ptr <= r_init_ptr + 1'b1;
      if (w_conflict)
        r_prio_rd <= ~r_prio_rd;
      r_pend <= w_grant_r;
      if (r_pend)
        r_hold <= bus.RW0_rdata;
    end
  end

  assign bus.r_ready      = w_grant_r;
  assign bus.w_ready      = w_grant_w;
  assign bus.RW0_en       = w_en;
  assign bus.RW0_wmode    = w_wmode;
  assign bus.RW0_addr     = w_addr_mux;
  assign bus.RW0_wmask    = w_wmask_mux;
  assign bus.RW0_wdata    = w_wdata_mux;
  assign bus.r_resp_valid = r_pend;
  assign bus.r_resp_data  = r_pend ? bus.RW0_rdata : r_hold;
  assign bus.init_done    = r_init_done;

endmodule

// File: tb/tb_sram_rw0_ctrl.sv
// Randomized bench for sram_rw0_ctrl with a behavioural SRAM macro and a
// transaction-level reference model of arbitration, sweep and read return.
module tb_sram_rw0_ctrl;
  localparam int DEPTH  = 128;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 160;
  localparam int LANES  = 4;
  localparam int LW     = DATA_W / LANES;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sram_rw0_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LANES(LANES)) ifc ();

  sram_rw0_ctrl #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LANES(LANES), .INIT_EN(1)
  ) dut (
    .clock  (clk),
    .reset_n(rst_n),
    .bus    (ifc.slave)
  );

  // Behavioural macro: lane-masked write, registered read, garbage when not reading.
  logic [DATA_W-1:0] sram [DEPTH];
  always @(posedge clk) begin
    if (ifc.RW0_en && ifc.RW0_wmode) begin
      for (int l = 0; l < LANES; l++)
        if (ifc.RW0_wmask[l]) sram[ifc.RW0_addr][l*LW +: LW] <= ifc.RW0_wdata[l*LW +: LW];
    end
    if (ifc.RW0_en && !ifc.RW0_wmode)
      ifc.RW0_rdata <= sram[ifc.RW0_addr];
    else
      ifc.RW0_rdata <= {$urandom, $urandom, $urandom, $urandom, $urandom};
  end

  // Reference model state
  logic [DATA_W-1:0] m_mem [DEPTH];
  int                m_init_cnt;
  bit                m_w_turn;
  bit                m_pend;
  logic [DATA_W-1:0] m_resp;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_init_cnt = 0;
    m_w_turn   = 1'b1;
    m_pend     = 1'b0;
    m_resp     = '0;
  endtask

  // One clock cycle: drive, check at negedge, advance model after the edge.
  task automatic step(input bit rv, input logic [ADDR_W-1:0] ra, input bit wv,
                      input logic [ADDR_W-1:0] wa, input logic [LANES-1:0] wm,
                      input logic [DATA_W-1:0] wd);
    bit                gw, gr, in_init;
    logic [ADDR_W-1:0] e_addr;
    logic [LANES-1:0]  e_mask;
    logic [DATA_W-1:0] e_wdata;
    ifc.r_valid = rv; ifc.r_addr = ra;
    ifc.w_valid = wv; ifc.w_addr = wa; ifc.w_mask = wm; ifc.w_data = wd;
    @(negedge clk);
    in_init = (m_init_cnt < DEPTH);
    gw = 1'b0; gr = 1'b0; e_addr = '0; e_mask = '0; e_wdata = '0;
    if (in_init) begin
      e_addr = ADDR_W'(m_init_cnt);
      e_mask = '1;
    end else begin
      gw = wv && (!rv || m_w_turn);
      gr = rv && !gw;
      if (gw) begin e_addr = wa; e_mask = wm; e_wdata = wd; end
      else if (gr) e_addr = ra;
    end
    chk("r_ready",      DATA_W'(ifc.r_ready),      DATA_W'(gr));
    chk("w_ready",      DATA_W'(ifc.w_ready),      DATA_W'(gw));
    chk("RW0_en",       DATA_W'(ifc.RW0_en),       DATA_W'(in_init || gw || gr));
    chk("RW0_wmode",    DATA_W'(ifc.RW0_wmode),    DATA_W'(in_init || gw));
    chk("RW0_addr",     DATA_W'(ifc.RW0_addr),     DATA_W'(e_addr));
    chk("RW0_wmask",    DATA_W'(ifc.RW0_wmask),    DATA_W'(e_mask));
    chk("RW0_wdata",    ifc.RW0_wdata,             e_wdata);
    chk("init_done",    DATA_W'(ifc.init_done),    DATA_W'(!in_init));
    chk("r_resp_valid", DATA_W'(ifc.r_resp_valid), DATA_W'(m_pend));
    chk("r_resp_data",  ifc.r_resp_data,           m_resp);
    @(posedge clk); #1;
    if (in_init) begin
      m_mem[m_init_cnt] = '0;
      m_init_cnt++;
    end else begin
      if (gw)
        for (int l = 0; l < LANES; l++)
          if (wm[l]) m_mem[wa][l*LW +: LW] = wd[l*LW +: LW];
      if (rv && wv) m_w_turn = !gw;
      m_pend = gr;
      if (gr) m_resp = m_mem[ra];
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, '0, '0);
  endtask

  // Assert reset with a read request pending and check the quiet reset values.
  task automatic apply_reset();
    rst_n = 1'b0;
    ifc.r_valid = 1'b1; ifc.r_addr = 7'd9;
    ifc.w_valid = 1'b1; ifc.w_addr = 7'd4; ifc.w_mask = 4'hF; ifc.w_data = '1;
    model_reset();
    @(negedge clk);
    chk("rst r_ready",      DATA_W'(ifc.r_ready),      '0);
    chk("rst w_ready",      DATA_W'(ifc.w_ready),      '0);
    chk("rst r_resp_valid", DATA_W'(ifc.r_resp_valid), '0);
    chk("rst r_resp_data",  ifc.r_resp_data,           '0);
    chk("rst RW0_en",       DATA_W'(ifc.RW0_en),       '0);
    chk("rst RW0_wmode",    DATA_W'(ifc.RW0_wmode),    '0);
    chk("rst RW0_addr",     DATA_W'(ifc.RW0_addr),     '0);
    chk("rst RW0_wmask",    DATA_W'(ifc.RW0_wmask),    '0);
    chk("rst RW0_wdata",    ifc.RW0_wdata,             '0);
    chk("rst init_done",    DATA_W'(ifc.init_done),    '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic random_run(input int n);
    for (int i = 0; i < n; i++)
      step(1'($urandom), ADDR_W'($urandom_range(15)), 1'($urandom), ADDR_W'($urandom_range(15)),
           LANES'($urandom), {$urandom, $urandom, $urandom, $urandom, $urandom});
  endtask

  logic [DATA_W-1:0] pat_a;

  initial begin
    rst_n = 1'b0;
    ifc.r_valid = 1'b0; ifc.r_addr = '0;
    ifc.w_valid = 1'b0; ifc.w_addr = '0; ifc.w_mask = '0; ifc.w_data = '0;
    apply_reset();

    // Read held through the whole sweep, accepted on the first RUN cycle.
    for (int i = 0; i < DEPTH + 1; i++) step(1'b1, 7'd5, 1'b0, '0, '0, '0);
    idle(1);

    // Lane-masked write then immediate read of the same address.
    step(1'b0, '0, 1'b1, 7'd3, 4'b0101, '1);
    step(1'b1, 7'd3, 1'b0, '0, '0, '0);
    idle(1);

    // Sustained contention.
    for (int i = 0; i < 6; i++) step(1'b1, 7'd3, 1'b1, 7'd8, 4'hF, {5{$urandom}});
    idle(1);

    // Single read followed by idle cycles: data must be held.
    pat_a = {$urandom, $urandom, $urandom, $urandom, $urandom};
    step(1'b0, '0, 1'b1, 7'd7, 4'hF, pat_a);
    step(1'b1, 7'd7, 1'b0, '0, '0, '0);
    idle(5);

    // Back-to-back reads.
    for (int i = 0; i < 4; i++) step(1'b1, ADDR_W'(i + 3), 1'b0, '0, '0, '0);
    idle(1);

    random_run(400);

    // Reset in the middle of the sweep.
    apply_reset();
    for (int i = 0; i < 60; i++) step(1'b0, '0, 1'b1, 7'd2, 4'hF, '1);
    apply_reset();
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b0, '0, '0, '0);
    random_run(60);

    // Reset the cycle after a read grant: the response is discarded.
    step(1'b0, '0, 1'b1, 7'd11, 4'hF, '1);
    step(1'b1, 7'd11, 1'b0, '0, '0, '0);
    apply_reset();
    idle(DEPTH);
    step(1'b1, 7'd11, 1'b0, '0, '0, '0);
    idle(1);
    random_run(150);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sram_rw0_ctrl.md
# sram_rw0_ctrl

Access controller for the 128-entry × 160-bit single-port, lane-masked SRAM macros (one shared RW0 port, 4 × 40-bit write lanes, 1-cycle registered read). It arbitrates independent read and write request channels onto the single RW0 port. At reset it sweeps the whole array to zero. It returns read data with a valid strobe and holds that data stable until the next read completes, so consumers never see the macro's undefined output on non-read cycles.

## Interface
- `DEPTH`, 128: number of array entries
- `ADDR_W`, 7: address width, equal to log2(DEPTH)
- `DATA_W`, 160: entry width
- `LANES`, 4: write-mask lanes; lane width is DATA_W/LANES = 40
- `INIT_EN`, 1: 1 = zero-fill the array after reset; 0 = go straight to RUN
- `clock`  in  1  sole clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `r_valid`  in  1  read request
- `r_ready`  out  1  read request accepted this cycle
- `r_addr`  in  ADDR_W  read address
- `r_resp_valid`  out  1  read data valid, one-cycle pulse
- `r_resp_data`  out  DATA_W  read data, held until the next response
- `w_valid`  in  1  write request
- `w_ready`  out  1  write request accepted this cycle
- `w_addr`  in  ADDR_W  write address
- `w_mask`  in  LANES  per-lane write enable
- `w_data`  in  DATA_W  write data
- `init_done`  out  1  high once the array is usable
- `RW0_addr`  out  ADDR_W  macro address
- `RW0_en`  out  1  macro enable
- `RW0_wmode`  out  1  1 = write, 0 = read
- `RW0_wmask`  out  LANES  macro lane mask
- `RW0_wdata`  out  DATA_W  macro write data
- `RW0_rdata`  in  DATA_W  macro read data, valid the cycle after a read enable

## Operation
- The FSM has two states, INIT and RUN.
- Reset state is INIT if INIT_EN=1, otherwise RUN.
- **INIT**
  - An `init_ptr` counter starts at 0.
  - Each cycle drives RW0_en=1, RW0_wmode=1, RW0_wmask=all-ones, RW0_wdata=0, RW0_addr=init_ptr.
  - The counter increments each cycle. At init_ptr==DEPTH-1 the FSM moves to RUN.
  - r_ready=w_ready=0 throughout. Requests wait; they are not dropped.
- **RUN**
  - At most one macro operation per cycle.
  - Both valid, no conflict history: the write wins.
  - After a conflict cycle is granted to one side, a 1-bit `prio` flips to favour the other side for the next conflict.
  - `prio` updates only on conflict cycles. Its reset value is W.
  - w_ready = RUN && w_valid && (prio==W || !r_valid).
  - r_ready = RUN && r_valid && (prio==R || !w_valid).
  - RW0_en = r_ready|w_ready.
  - RW0_wmode = w_ready.
  - RW0_addr, RW0_wmask and RW0_wdata are muxed from the granted channel.
  - RW0_wmask=0 when not writing.
  - A write with w_mask=0 is still accepted and enables the macro.
- **Read return**
  - `r_pend` is registered from r_ready.
  - r_resp_valid = r_pend.
  - r_resp_data = RW0_rdata when r_pend is high, otherwise `hold_q`.
  - `hold_q` loads RW0_rdata on every cycle where r_pend is high.
- init_done = (state==RUN), registered.
- **Reset mid-operation:** reset_n low forces INIT (or RUN when INIT_EN=0), clears init_ptr, prio, r_pend and hold_q. An in-flight read response is discarded.

## Timing
- Reset values:
  - r_ready=0, w_ready=0, r_resp_valid=0, r_resp_data=0
  - RW0_en=0, RW0_wmode=0, RW0_addr=0, RW0_wmask=0, RW0_wdata=0
  - init_done=0 (INIT_EN=1) or 1 (INIT_EN=0)
- Once reset is released, INIT drives RW0_en combinationally from the first clock.
- The INIT sweep takes exactly DEPTH cycles. init_done rises on the edge that ends the last init write. Requests can be accepted from cycle DEPTH onward.
- Read latency: request accepted in cycle N → r_resp_valid and data in cycle N+1, combinational from RW0_rdata.
- Write-then-read to the same address in consecutive cycles returns the new data. The macro commits on the edge.
- Back-to-back reads sustain 1 per cycle.
- Under continuous contention, each side is granted every other cycle, starting with the write.
- Handshake: valid must not depend on ready. Ready may depend on both valids. There are no combinational paths from RW0_rdata to any ready.

## Test plan
- Reset with INIT_EN=1, hold r_valid=1 at addr 5 → r_ready=0 for 128 cycles; RW0 writes addr 0..127 with data 0 and mask 4'hF; init_done rises; the read is accepted at cycle 128; response data = 0.
- Write addr 3, mask 4'b0101, data all-ones; next cycle read addr 3 → r_resp_data = lanes 0 and 2 all-ones, lanes 1 and 3 zero.
- r_valid and w_valid held high together for 6 cycles → grants alternate W,R,W,R,W,R; r_resp_valid pulses on the cycles after each R grant.
- Read addr 7 (data A), then idle 5 cycles → r_resp_valid is a 1-cycle pulse; r_resp_data stays A for all 5 idle cycles; no macro reads are issued.
- Assert reset_n low at init_ptr=60, release → the sweep restarts at addr 0 and takes a full 128 cycles. Assert reset_n low the cycle after a read grant → no r_resp_valid, r_resp_data = 0.
